// File: rtl/fetch_dual_issue.sv
// Dual-issue instruction fetch stage: owns the PC, drives two fetch addresses
// into a combinational dual-port instruction memory, resolves `j` locally and
// registers a two-slot IF/ID bundle for decode.
module fetch_dual_issue #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter logic [5:0]  JUMP_OPCODE  = 6'b000010,
    parameter logic [31:0] INVALID_WORD = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD     = 32'h3800_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] dato_instru_1,
    input  logic [31:0] dato_instru_2,
    output logic [31:0] dir_instru_1,
    output logic [31:0] dir_instru_2,
    output logic        read_mem_1_n,
    output logic        read_mem_2_n,
    output logic [31:0] id_instr_1,
    output logic [31:0] id_instr_2,
    output logic [31:0] id_pc_1,
    output logic [31:0] id_pc_2,
    output logic        id_valid_1,
    output logic        id_valid_2,
    output logic        halted
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHalt  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_1_q, id_instr_1_d;
    logic [31:0] id_instr_2_q, id_instr_2_d;
    logic [31:0] id_pc_1_q, id_pc_1_d;
    logic [31:0] id_pc_2_q, id_pc_2_d;
    logic        id_valid_1_q, id_valid_1_d;
    logic        id_valid_2_q, id_valid_2_d;
    logic        halted_q, halted_d;

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;

    // Next-state logic: flush beats stall beats a normal fetch edge.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_instr_1_d = id_instr_1_q;
        id_instr_2_d = id_instr_2_q;
        id_pc_1_d    = id_pc_1_q;
        id_pc_2_d    = id_pc_2_q;
        id_valid_1_d = id_valid_1_q;
        id_valid_2_d = id_valid_2_q;
        halted_d     = halted_q;

        if (flush_i) begin
            pc_d         = {redirect_pc_i[31:2], 2'b00};
            id_valid_1_d = 1'b0;
            id_valid_2_d = 1'b0;
            id_instr_1_d = NOP_WORD;
            id_instr_2_d = NOP_WORD;
            state_d      = StFetch;
            halted_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    if (!stall_i) begin
                        id_pc_1_d    = pc_q;
                        id_pc_2_d    = pc_plus4;
                        id_instr_1_d = dato_instru_1;
                        id_instr_2_d = dato_instru_2;
                        id_valid_1_d = 1'b1;
                        id_valid_2_d = 1'b1;
                        pc_d         = pc_plus8;
                        // Invalid beats jump within a slot; a slot-1 jump hides slot 2.
                        if (dato_instru_1 == INVALID_WORD) begin
                            id_valid_1_d = 1'b0;
                            id_valid_2_d = 1'b0;
                            id_instr_1_d = NOP_WORD;
                            id_instr_2_d = NOP_WORD;
                            state_d      = StHalt;
                            halted_d     = 1'b1;
                            pc_d         = pc_q;
                        end else if (dato_instru_1[31:26] == JUMP_OPCODE) begin
                            id_valid_2_d = 1'b0;
                            id_instr_2_d = NOP_WORD;
                            pc_d         = {pc_plus4[31:28], dato_instru_1[25:0], 2'b00};
                        end else if (dato_instru_2 == INVALID_WORD) begin
                            id_valid_2_d = 1'b0;
                            id_instr_2_d = NOP_WORD;
                            state_d      = StHalt;
                            halted_d     = 1'b1;
                            pc_d         = pc_q;
                        end else if (dato_instru_2[31:26] == JUMP_OPCODE) begin
                            pc_d = {pc_plus8[31:28], dato_instru_2[25:0], 2'b00};
                        end
                    end
                end
                StHalt: begin
                    id_valid_1_d = 1'b0;
                    id_valid_2_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            id_instr_1_q <= NOP_WORD;
            id_instr_2_q <= NOP_WORD;
            id_pc_1_q    <= 32'd0;
            id_pc_2_q    <= 32'd0;
            id_valid_1_q <= 1'b0;
            id_valid_2_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            id_instr_1_q <= id_instr_1_d;
            id_instr_2_q <= id_instr_2_d;
            id_pc_1_q    <= id_pc_1_d;
            id_pc_2_q    <= id_pc_2_d;
            id_valid_1_q <= id_valid_1_d;
            id_valid_2_q <= id_valid_2_d;
            halted_q     <= halted_d;
        end
    end

    // Memory interface is driven straight from the PC and state.
    always_comb begin
        dir_instru_1 = pc_q;
        dir_instru_2 = pc_plus4;
        read_mem_1_n = (state_q != StFetch);
        read_mem_2_n = (state_q != StFetch);
    end

    assign id_instr_1 = id_instr_1_q;
    assign id_instr_2 = id_instr_2_q;
    assign id_pc_1    = id_pc_1_q;
    assign id_pc_2    = id_pc_2_q;
    assign id_valid_1 = id_valid_1_q;
    assign id_valid_2 = id_valid_2_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_dual_issue.sv
// Directed bench for fetch_dual_issue with a small combinational memory image.
module tb_fetch_dual_issue;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] dato_instru_1;
    logic [31:0] dato_instru_2;
    logic [31:0] dir_instru_1;
    logic [31:0] dir_instru_2;
    logic        read_mem_1_n;
    logic        read_mem_2_n;
    logic [31:0] id_instr_1;
    logic [31:0] id_instr_2;
    logic [31:0] id_pc_1;
    logic [31:0] id_pc_2;
    logic        id_valid_1;
    logic        id_valid_2;
    logic        halted;

    int checks_q;
    int errors_q;

    fetch_dual_issue dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .dato_instru_1 (dato_instru_1),
        .dato_instru_2 (dato_instru_2),
        .dir_instru_1  (dir_instru_1),
        .dir_instru_2  (dir_instru_2),
        .read_mem_1_n  (read_mem_1_n),
        .read_mem_2_n  (read_mem_2_n),
        .id_instr_1    (id_instr_1),
        .id_instr_2    (id_instr_2),
        .id_pc_1       (id_pc_1),
        .id_pc_2       (id_pc_2),
        .id_valid_1    (id_valid_1),
        .id_valid_2    (id_valid_2),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image; everything not listed is a non-jump addi encoding.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0040_0000: mem_rd = 32'h3800_0000;
            32'h0040_0004: mem_rd = 32'h8D71_0001;
            32'h0040_006C: mem_rd = 32'hA512_A023;
            32'h0040_0070: mem_rd = 32'h0810_0021;
            32'h0040_0084: mem_rd = 32'h852A_B021;
            32'h0040_0088: mem_rd = 32'hFFFF_FFFF;
            default:       mem_rd = {6'b001000, a[25:0]};
        endcase
    endfunction

    always_comb begin
        dato_instru_1 = mem_rd(dir_instru_1);
        dato_instru_2 = mem_rd(dir_instru_2);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q++;
        if (got !== exp) begin
            errors_q++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " dir1"}, dir_instru_1, 32'h0040_0000);
        check_eq({tag, " dir2"}, dir_instru_2, 32'h0040_0004);
        check_eq({tag, " rd_n"}, {30'd0, read_mem_1_n, read_mem_2_n}, 32'd3);
        check_eq({tag, " instr1"}, id_instr_1, 32'h3800_0000);
        check_eq({tag, " instr2"}, id_instr_2, 32'h3800_0000);
        check_eq({tag, " pc1"}, id_pc_1, 32'd0);
        check_eq({tag, " pc2"}, id_pc_2, 32'd0);
        check_eq({tag, " valid"}, {30'd0, id_valid_1, id_valid_2}, 32'd0);
        check_eq({tag, " halted"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        checks_q      = 0;
        errors_q      = 0;
        rst           = 1'b1;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_pc_i = 32'd0;

        // Reset
        step();
        check_reset_vals("reset");

        // Test 1: release, IDLE -> FETCH, then first bundle
        rst = 1'b0;
        step();
        check_eq("t1 rd_n", {30'd0, read_mem_1_n, read_mem_2_n}, 32'd0);
        check_eq("t1 dir1", dir_instru_1, 32'h0040_0000);
        check_eq("t1 dir2", dir_instru_2, 32'h0040_0004);
        check_eq("t1 valid idle", {30'd0, id_valid_1, id_valid_2}, 32'd0);
        step();
        check_eq("t1 pc1", id_pc_1, 32'h0040_0000);
        check_eq("t1 pc2", id_pc_2, 32'h0040_0004);
        check_eq("t1 instr1", id_instr_1, 32'h3800_0000);
        check_eq("t1 instr2", id_instr_2, 32'h8D71_0001);
        check_eq("t1 valid", {30'd0, id_valid_1, id_valid_2}, 32'd3);
        check_eq("t1 dir1 next", dir_instru_1, 32'h0040_0008);
        check_eq("t1 dir2 next", dir_instru_2, 32'h0040_000C);

        // Test 2: sequential run up to the jump at 0x00400070
        for (int i = 0; i < 13; i++) step();
        check_eq("t2 dir1 at jump", dir_instru_1, 32'h0040_0070);
        step();
        check_eq("t2 pc1", id_pc_1, 32'h0040_0070);
        check_eq("t2 instr1", id_instr_1, 32'h0810_0021);
        check_eq("t2 instr2", id_instr_2, 32'h3800_0000);
        check_eq("t2 valid", {30'd0, id_valid_1, id_valid_2}, 32'd2);
        check_eq("t2 dir1", dir_instru_1, 32'h0040_0084);

        // Test 4: stall for 3 cycles with a flush on the second
        stall_i = 1'b1;
        step();
        check_eq("t4 stall dir1", dir_instru_1, 32'h0040_0084);
        check_eq("t4 stall instr1", id_instr_1, 32'h0810_0021);
        check_eq("t4 stall valid", {30'd0, id_valid_1, id_valid_2}, 32'd2);
        check_eq("t4 stall rd_n", {30'd0, read_mem_1_n, read_mem_2_n}, 32'd0);
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0040_0000;
        step();
        check_eq("t4 flush valid", {30'd0, id_valid_1, id_valid_2}, 32'd0);
        check_eq("t4 flush dir1", dir_instru_1, 32'h0040_0000);
        check_eq("t4 flush instr1", id_instr_1, 32'h3800_0000);
        flush_i = 1'b0;
        step();
        check_eq("t4 stall3 dir1", dir_instru_1, 32'h0040_0000);
        check_eq("t4 stall3 pc1", id_pc_1, 32'h0040_0070);
        stall_i = 1'b0;

        // Test 3: misaligned redirect, jump in slot 2
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0040_006E;
        step();
        flush_i = 1'b0;
        check_eq("t3 dir1", dir_instru_1, 32'h0040_006C);
        check_eq("t3 valid after flush", {30'd0, id_valid_1, id_valid_2}, 32'd0);
        step();
        check_eq("t3 instr1", id_instr_1, 32'hA512_A023);
        check_eq("t3 instr2", id_instr_2, 32'h0810_0021);
        check_eq("t3 pc2", id_pc_2, 32'h0040_0070);
        check_eq("t3 valid", {30'd0, id_valid_1, id_valid_2}, 32'd3);
        check_eq("t3 dir1 next", dir_instru_1, 32'h0040_0084);

        // Test 5: invalid word in slot 2 halts
        step();
        check_eq("t5 instr1", id_instr_1, 32'h852A_B021);
        check_eq("t5 instr2", id_instr_2, 32'h3800_0000);
        check_eq("t5 valid", {30'd0, id_valid_1, id_valid_2}, 32'd2);
        check_eq("t5 halted", {31'd0, halted}, 32'd1);
        check_eq("t5 rd_n", {30'd0, read_mem_1_n, read_mem_2_n}, 32'd3);
        check_eq("t5 dir1 frozen", dir_instru_1, 32'h0040_0084);
        step();
        check_eq("t5 halt valid", {30'd0, id_valid_1, id_valid_2}, 32'd0);
        check_eq("t5 halt halted", {31'd0, halted}, 32'd1);
        check_eq("t5 halt dir1", dir_instru_1, 32'h0040_0084);
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0040_0000;
        step();
        flush_i = 1'b0;
        check_eq("t5 resume halted", {31'd0, halted}, 32'd0);
        check_eq("t5 resume rd_n", {30'd0, read_mem_1_n, read_mem_2_n}, 32'd0);
        check_eq("t5 resume dir1", dir_instru_1, 32'h0040_0000);

        // Test 6a: reset during stall
        stall_i = 1'b1;
        step();
        rst = 1'b1;
        step();
        check_reset_vals("t6 stall rst");
        rst     = 1'b0;
        stall_i = 1'b0;
        step();
        check_eq("t6 fetch rd_n", {30'd0, read_mem_1_n, read_mem_2_n}, 32'd0);
        check_eq("t6 fetch valid", {30'd0, id_valid_1, id_valid_2}, 32'd0);
        step();
        check_eq("t6 first pc1", id_pc_1, 32'h0040_0000);
        check_eq("t6 first valid", {30'd0, id_valid_1, id_valid_2}, 32'd3);

        // Slot-1 invalid: both slots squashed, pc holds
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0040_0088;
        step();
        flush_i = 1'b0;
        step();
        check_eq("s1inv valid", {30'd0, id_valid_1, id_valid_2}, 32'd0);
        check_eq("s1inv instr1", id_instr_1, 32'h3800_0000);
        check_eq("s1inv halted", {31'd0, halted}, 32'd1);
        check_eq("s1inv dir1", dir_instru_1, 32'h0040_0088);

        // Test 6b: reset during HALT
        rst = 1'b1;
        step();
        check_reset_vals("t6 halt rst");
        rst = 1'b0;
        step();
        check_eq("t6 halt fetch rd_n", {30'd0, read_mem_1_n, read_mem_2_n}, 32'd0);

        // Test 6c: PC wrap
        flush_i       = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        step();
        flush_i = 1'b0;
        check_eq("wrap dir1", dir_instru_1, 32'hFFFF_FFF8);
        check_eq("wrap dir2", dir_instru_2, 32'hFFFF_FFFC);
        step();
        check_eq("wrap next dir1", dir_instru_1, 32'h0000_0000);
        check_eq("wrap pc2", id_pc_2, 32'hFFFF_FFFC);
        check_eq("wrap instr2", id_instr_2, {6'b001000, 26'h3FF_FFFC});
        check_eq("wrap valid", {30'd0, id_valid_1, id_valid_2}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
        $finish;
    end

endmodule

// File: doc/fetch_dual_issue.md
Name: fetch_dual_issue

Overview:
Dual-issue instruction fetch stage for the superscalar MIPS core. It sits directly upstream of the dual-port instruction memory: it owns the PC, drives two fetch addresses (PC, PC+4) and active-low read enables, and captures the two returned words. It resolves `j` instructions locally and registers a two-slot IF/ID bundle (instruction, PC, valid) for decode. It supports stall from decode and redirect/flush from later stages.

Parameters:
RESET_PC, 32'h00400000, PC loaded on reset
JUMP_OPCODE, 6'b000010, opcode field [31:26] recognised as `j`
INVALID_WORD, 32'hFFFFFFFF, word the memory returns for an unmapped address
NOP_WORD, 32'h38000000, instruction value placed in squashed or empty slots

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active high
stall_i  in  1  decode cannot accept; hold PC and IF/ID
flush_i  in  1  redirect from a later stage; priority over stall_i
redirect_pc_i  in  32  new PC when flush_i=1; bits [1:0] forced to 0
dato_instru_1  in  32  word at dir_instru_1 (combinational memory return)
dato_instru_2  in  32  word at dir_instru_2
dir_instru_1  out  32  fetch address slot 1 = pc
dir_instru_2  out  32  fetch address slot 2 = pc+4
read_mem_1_n  out  1  active-low read enable, slot 1
read_mem_2_n  out  1  active-low read enable, slot 2
id_instr_1, id_instr_2  out  32  registered instructions
id_pc_1, id_pc_2  out  32  registered PCs of each slot
id_valid_1, id_valid_2  out  1  slot valid
halted  out  1  fetch stopped on INVALID_WORD

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; state=IDLE; id_instr_*=NOP_WORD; id_pc_*=0; id_valid_*=0; halted=0. Read enables are 1 during IDLE and HALT.
- dir_instru_1=pc and dir_instru_2=pc+4 at all times, mod 2^32.
- States: IDLE -> FETCH unconditionally on the first edge after rst=0. FETCH -> HALT on an invalid word. HALT -> FETCH only on flush_i. Any state -> IDLE on rst.
- FETCH: read_mem_*_n=0. Memory is combinational, so the words are captured at the same edge the address is driven. Fetch-to-decode latency is 1 cycle.
- FETCH edge priority, highest first: rst, flush_i, stall_i, normal.
- flush_i: pc<=redirect_pc_i & ~3; id_valid_*<=0; id_instr_*<=NOP_WORD; state<=FETCH; halted<=0. This applies in FETCH, HALT or under stall.
- stall_i (no flush): pc and all id_* hold. Read enables stay 0.
- Normal edge: id_pc_1<=pc, id_pc_2<=pc+4, id_instr_k<=dato_instru_k, id_valid_k<=1, then these overrides apply:
  - Slot1 invalid (dato_instru_1==INVALID_WORD): both slots invalid with NOP_WORD; state<=HALT; halted<=1; pc holds.
  - Slot2 invalid only: slot1 handled normally, slot2 invalid with NOP_WORD; HALT; halted<=1.
  - Jump in slot1 (dato_instru_1[31:26]==JUMP_OPCODE): slot2 squashed (valid 0, NOP_WORD). pc<={ (pc+4)[31:28], dato_instru_1[25:0], 2'b00 }.
  - Jump in slot2 only: both valid. pc<={ (pc+8)[31:28], dato_instru_2[25:0], 2'b00 }.
  - Otherwise pc<=pc+8, wrapping mod 2^32 (0xFFFFFFF8 -> 0x00000000).
  - There are no delay slots.
  - Invalid-word checks take precedence over jump checks in the same slot. A slot1 jump means slot2 is never checked for invalid.
- HALT: id_valid_*<=0 on the first HALT edge and thereafter; halted stays 1; pc frozen.
- NOP_WORD fetched from memory is a normal valid instruction.

Test Plan:
1. Release rst, memory image from 0x00400000 -> edge 1 IDLE->FETCH, read_mem_*_n=0, dir=0x00400000/0x00400004. Edge 2: id_pc_1=0x00400000, id_instr_1=0x38000000, id_instr_2=0x8D710001, both valid. dir becomes 0x00400008/0x0040000C.
2. Run sequentially to pc=0x00400070 (slot1=0x08100021) -> id_valid_1=1, id_valid_2=0 with id_instr_2=0x38000000. Next dir_instru_1=0x00400084.
3. flush_i with redirect_pc_i=0x0040006E -> pc=0x0040006C. Slot1=0xA512A023, slot2=0x08100021 -> both valid, next pc=0x00400084.
4. stall_i=1 for 3 cycles mid-stream -> pc and id_* unchanged. Assert flush_i on cycle 2 of the stall with redirect 0x00400000 -> valids 0 next edge, pc=0x00400000.
5. pc=0x00400084: slot1=0x852AB021, slot2 at 0x00400088=0xFFFFFFFF -> id_valid_1=1, id_valid_2=0, halted=1. Read enables go 1 next cycle, and a further edge drops id_valid_1 to 0. flush_i to 0x00400000 resumes and clears halted.
6. rst=1 for one edge during stall and during HALT -> all outputs take reset values at that edge, pc=0x00400000. FETCH resumes 1 edge after release. Also force pc=0xFFFFFFF8 via flush with non-jump words -> next pc=0x00000000.
